crossing_scheduler: RTL

Demand-driven scheduler for a single pedestrian crossing. It rests the road in green and serves pedestrians only on a latched push-button request, after a minimum road-green time. It sequences the five crossing lamps plus a "wait" indicator from one 16 MHz clock, replacing a fixed-cycle light controller at the top of the crossing design.

---
 rtl/crossing_pkg.sv | 22 ++
 rtl/crossing_scheduler_if.sv | 9 +
 rtl/crossing_scheduler_ped_button_debounce.sv | 50 +++++
 rtl/crossing_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared types for the demand-driven crossing scheduler:
// phase enum, lamp patterns {ped_red,ped_green,red,yellow,green}.
package crossing_pkg;

  typedef enum logic [2:0] {
    ALL_RED    = 3'd0,
    ROAD_GREEN = 3'd1,
    YELLOW     = 3'd2,
    PED_GREEN  = 3'd3,
    PED_CLEAR  = 3'd4
  } state_e;

  localparam int SEC_W = 6;

  localparam logic [4:0] LAMP_ALL_RED   = 5'b10100;
  localparam logic [4:0] LAMP_ROAD_GRN  = 5'b10001;
  localparam logic [4:0] LAMP_YELLOW    = 5'b10010;
  localparam logic [4:0] LAMP_PED_GRN   = 5'b01100;
  localparam logic [4:0] LAMP_PED_CLEAR = 5'b10100;
  localparam logic [4:0] LAMP_FLASH_OFF = 5'b00100;

endpackage

// File: rtl/crossing_scheduler_if.sv
// Lamp bundle of the crossing scheduler: five lamps plus wait lamp.
// master drives lamps/req_lamp, slave observes them.
interface crossing_scheduler_if;
  logic [4:0] lamps;
  logic       req_lamp;

  modport master (output lamps, output req_lamp);
  modport slave  (input lamps, input req_lamp);
endinterface

// File: rtl/crossing_scheduler_ped_button_debounce.sv
// Push-button conditioner: 2-flop synchronizer then debouncer.
// Ports: clk_i, rst_i (sync, high), btn_i (async), level_o.
module ped_button_debounce #(
  parameter int DEBOUNCE_TICKS = 160000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count restarts whenever the input matches the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/crossing_scheduler.sv
// Demand-driven pedestrian crossing scheduler, road rests green.
// Ports: pin3 clk, pin9 rst, pin10/11 buttons, pin4-8 lamps, pin12 wait.
// Option: PED_FLASH_EN flashes ped_green at 1 Hz in PED_CLEAR.
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int TIMER_SCALE    = 16000000,
  parameter int T_MIN_GREEN    = 10,
  parameter int T_YELLOW       = 3,
  parameter int T_ALL_RED      = 2,
  parameter int T_PED_GREEN    = 8,
  parameter int T_PED_CLEAR    = 3,
  parameter int DEBOUNCE_TICKS = 160000
) (
  input  logic pin3_clk_16mhz,
  input  logic pin9_rst,
  input  logic pin10_ped_btn_a,
  input  logic pin11_ped_btn_b,
  output logic pin4_green,
  output logic pin5_yellow,
  output logic pin6_red,
  output logic pin7_ped_green,
  output logic pin8_ped_red,
  output logic pin12_wait
);

  localparam int PW = $clog2(TIMER_SCALE);

  logic             lvl_a;
  logic             lvl_b;
  logic             lvl_a_q;
  logic             lvl_b_q;
  logic             rise;
  state_e           state_q;
  state_e           state_d;
  logic             boot_q;
  logic             boot_d;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [SEC_W-1:0] sec_q;
  logic [SEC_W-1:0] sec_d;
  logic             req_q;
  logic             req_d;
  logic [4:0]       lamps_q;
  logic [4:0]       lamps_d;
  logic             sec_tick;
  logic             expire;
  logic             enter;

  ped_button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_deb_a (
    .clk_i  (pin3_clk_16mhz),
    .rst_i  (pin9_rst),
    .btn_i  (pin10_ped_btn_a),
    .level_o(lvl_a)
  );

  ped_button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_deb_b (
    .clk_i  (pin3_clk_16mhz),
    .rst_i  (pin9_rst),
    .btn_i  (pin11_ped_btn_b),
    .level_o(lvl_b)
  );

  function automatic logic [SEC_W-1:0] dur(
    input state_e s
  );
    case (s)
      ROAD_GREEN: dur = SEC_W'(T_MIN_GREEN);
      YELLOW:     dur = SEC_W'(T_YELLOW);
      PED_GREEN:  dur = SEC_W'(T_PED_GREEN);
      PED_CLEAR:  dur = SEC_W'(T_PED_CLEAR);
      default:    dur = SEC_W'(T_ALL_RED);
    endcase
  endfunction

  assign rise = (lvl_a & ~lvl_a_q)
              | (lvl_b & ~lvl_b_q);

  assign sec_tick = (presc_q == PW'(TIMER_SCALE - 1));

  // sec_q==0 after reset also expires on the first tick.
  assign expire = sec_tick
               && (sec_q <= SEC_W'(1));

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    case (state_q)
      ALL_RED: begin
        if (expire) begin
          state_d = boot_q ? ROAD_GREEN
                           : PED_GREEN;
          boot_d  = 1'b0;
        end
      end
      ROAD_GREEN: begin
        // sec_q==0 means minimum green done: resting.
        if (req_q && (expire || sec_q == '0)) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (expire) state_d = ALL_RED;
      end
      PED_GREEN: begin
        if (expire) state_d = PED_CLEAR;
      end
      PED_CLEAR: begin
        if (expire) state_d = ROAD_GREEN;
      end
      default: begin
        state_d = ALL_RED;
        boot_d  = 1'b1;
      end
    endcase
  end

  assign enter = (state_d != state_q);

  always_comb begin
    presc_d = presc_q + 1'b1;
    sec_d   = sec_q;
    req_d   = req_q;
    if (enter || sec_tick) begin
      presc_d = '0;
    end
    if (enter) begin
      sec_d = dur(state_d);
    end else if (sec_tick && sec_q != '0) begin
      sec_d = sec_q - 1'b1;
    end
    if (rise && state_q != PED_GREEN) begin
      req_d = 1'b1;
    end
    if (enter && state_d == PED_GREEN) begin
      req_d = 1'b0;
    end
  end

  // Decode from next state so lamps move with the state register.
  always_comb begin
    lamps_d = LAMP_ALL_RED;
    case (state_d)
      ROAD_GREEN: lamps_d = LAMP_ROAD_GRN;
      YELLOW:     lamps_d = LAMP_YELLOW;
      PED_GREEN:  lamps_d = LAMP_PED_GRN;
      PED_CLEAR: begin
`ifdef PED_FLASH_EN
        lamps_d = (presc_d < PW'(TIMER_SCALE / 2))
                ? LAMP_PED_GRN
                : LAMP_FLASH_OFF;
`else
        lamps_d = LAMP_PED_CLEAR;
`endif
      end
      default:    lamps_d = LAMP_ALL_RED;
    endcase
  end

  always_ff @(posedge pin3_clk_16mhz) begin
    if (pin9_rst) begin
      state_q <= ALL_RED;
      boot_q  <= 1'b1;
      presc_q <= '0;
      sec_q   <= '0;
      req_q   <= 1'b0;
      lamps_q <= LAMP_ALL_RED;
      lvl_a_q <= 1'b0;
      lvl_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      req_q   <= req_d;
      lamps_q <= lamps_d;
      lvl_a_q <= lvl_a;
      lvl_b_q <= lvl_b;
    end
  end

  crossing_scheduler_if lamp_if ();

  assign lamp_if.lamps    = lamps_q;
  assign lamp_if.req_lamp = req_q;

  assign pin4_green     = lamp_if.lamps[0];
  assign pin5_yellow    = lamp_if.lamps[1];
  assign pin6_red       = lamp_if.lamps[2];
  assign pin7_ped_green = lamp_if.lamps[3];
  assign pin8_ped_red   = lamp_if.lamps[4];
  assign pin12_wait     = lamp_if.req_lamp;

endmodule
